// File: rtl/fifo_ctrl.sv
// Pointer and status controller for the UART RX/TX FIFOs: storage addresses,
// gated write enable, fill level and sticky overflow/underflow flags.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  err_clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned          Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  DepthCnt = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0]  AfLevel  = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_WIDTH-1:0] wp_inc, rp_inc;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    wr_acc = wr & ~full_q;
    rd_acc = rd & ~empty_q;
    wp_inc = wp_q + 1'b1;
    rp_inc = rp_q + 1'b1;

    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    empty_d = empty_q;
    full_d  = full_q;

    case ({wr_acc, rd_acc})
      2'b10: begin
        wp_d    = wp_inc;
        count_d = count_q + 1'b1;
        empty_d = 1'b0;
        full_d  = (wp_inc == rp_q);
      end
      2'b01: begin
        rp_d    = rp_inc;
        count_d = count_q - 1'b1;
        full_d  = 1'b0;
        empty_d = (rp_inc == wp_q);
      end
      // Simultaneous push and pop leaves the fill level untouched.
      2'b11: begin
        wp_d = wp_inc;
        rp_d = rp_inc;
      end
      default: ;
    endcase
  end

  // Error flags: clear first so a same-cycle set condition takes priority.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr & full_q & ~rd) overflow_d  = 1'b1;
    if (rd & empty_q)      underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    wr_en       = wr & ~full_q;
    w_addr      = wp_q;
    r_addr      = rp_q;
    empty       = empty_q;
    full        = full_q;
    count       = count_q;
    almost_full = (count_q >= AfLevel);
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

`ifndef SYNTHESIS
  a_not_empty_and_full : assert property (@(posedge clk) disable iff (reset)
    !(empty_q && full_q));
  a_count_bounded : assert property (@(posedge clk) disable iff (reset)
    count_q <= DepthCnt);
  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (reset)
    count_q == (full_q ? DepthCnt : {1'b0, wp_q - rp_q}));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized and directed bench for fifo_ctrl against a queue-based model of
// the FIFO plus a small storage array addressed by the DUT.
module tb_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          reset, wr, rd, err_clr;
  logic          wr_en, empty, full, almost_full, overflow, underflow;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;

  fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .rd         (rd),
    .err_clr    (err_clr),
    .wr_en      (wr_en),
    .w_addr     (w_addr),
    .r_addr     (r_addr),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: FIFO contents as a queue, pointers as plain modular counters.
  logic [7:0] mem[DEPTH];
  logic [7:0] q[$];
  int         mwp, mrp;
  bit         mov, mun;
  // Per-step observations for the test tasks to compare.
  bit         rd_hit, exp_wen;
  logic       got_wen;
  logic [7:0] rd_got, rd_exp;

  task automatic model_reset();
    q.delete();
    mwp = 0;
    mrp = 0;
    mov = 1'b0;
    mun = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit acc_w, acc_r;
    int sz;
    wr = w; rd = r; err_clr = c;
    #1;
    sz      = q.size();
    acc_w   = w && (sz < DEPTH);
    acc_r   = r && (sz > 0);
    exp_wen = acc_w;
    got_wen = wr_en;
    rd_hit  = acc_r;
    if (acc_r) begin
      rd_got = mem[r_addr];
      rd_exp = q.pop_front();
    end
    if (wr_en === 1'b1) mem[w_addr] = d;
    if (acc_w) q.push_back(d);
    mwp = (mwp + int'(acc_w)) % DEPTH;
    mrp = (mrp + int'(acc_r)) % DEPTH;
    if (w && sz == DEPTH && !r) mov = 1'b1;
    else if (c) mov = 1'b0;
    if (r && sz == 0) mun = 1'b1;
    else if (c) mun = 1'b0;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0; reset = 1'b1;
    #2;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (w_addr !== '0 || r_addr !== '0) begin
      bad++; $display("FAIL reset_addr got=%0d/%0d want=0/0", w_addr, r_addr);
    end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0 || almost_full !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", overflow, underflow, almost_full);
    end
    wr = 1'b1;
    #1;
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL reset_wr_en got=%b want=1", wr_en); end
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      total++; if (count !== 3'(i + 1)) begin
        bad++; $display("FAIL fill_count got=%0d want=%0d", count, i + 1);
      end
      total++; if (almost_full !== (i + 1 >= AF)) begin
        bad++; $display("FAIL fill_af got=%b want=%b at count %0d", almost_full, i + 1 >= AF, i + 1);
      end
    end
    total++; if (full !== 1'b1 || empty !== 1'b0) begin
      bad++; $display("FAIL fill_full got full=%b empty=%b want 1/0", full, empty);
    end
    total++; if (w_addr !== 2'd0) begin bad++; $display("FAIL fill_wrap got=%0d want=0", w_addr); end
  endtask

  task automatic test_overflow();
    // Continues from a full FIFO.
    step(1'b1, 1'b0, 1'b0, 8'hee);
    total++; if (got_wen !== 1'b0) begin bad++; $display("FAIL ovf_wr_en got=%b want=0", got_wen); end
    total++; if (count !== 3'd4 || w_addr !== 2'd0 || r_addr !== 2'd0 || full !== 1'b1) begin
      bad++; $display("FAIL ovf_state got cnt=%0d wa=%0d ra=%0d full=%b want 4/0/0/1",
                      count, w_addr, r_addr, full);
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
  endtask

  task automatic test_drain_wrap();
    logic [7:0] want[4];
    want[0] = 8'hc3; want[1] = 8'hd4; want[2] = 8'he5; want[3] = 8'hf6;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'ha1);
    step(1'b1, 1'b0, 1'b0, 8'hb2);
    step(1'b1, 1'b0, 1'b0, 8'hc3);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (rd_got !== 8'ha1) begin bad++; $display("FAIL drain_rd0 got=%h want=a1", rd_got); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'hd4);
    step(1'b1, 1'b0, 1'b0, 8'he5);
    step(1'b1, 1'b0, 1'b0, 8'hf6);
    total++; if (w_addr !== 2'd2) begin bad++; $display("FAIL drain_wwrap got=%0d want=2", w_addr); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (rd_got !== want[i]) begin
        bad++; $display("FAIL drain_rd%0d got=%h want=%h", i + 2, rd_got, want[i]);
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (underflow !== 1'b1 || r_addr !== 2'd2) begin
      bad++; $display("FAIL drain_unf got unf=%b ra=%0d want 1/2", underflow, r_addr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b1, 1'b1, 1'b0, 8'h03);
    total++; if (count !== 3'd2 || w_addr !== 2'd3 || r_addr !== 2'd1) begin
      bad++; $display("FAIL sim_mid got cnt=%0d wa=%0d ra=%0d want 2/3/1", count, w_addr, r_addr);
    end
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h04);
    total++; if (count !== 3'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
      bad++; $display("FAIL sim_empty got cnt=%0d unf=%b empty=%b want 1/1/0", count, underflow, empty);
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'h55);
    total++; if (count !== 3'd3 || overflow !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL sim_full got cnt=%0d ovf=%b full=%b want 3/0/0", count, overflow, full);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    #2;
    reset = 1'b1;
    #1;
    total++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || w_addr !== '0 ||
                 r_addr !== '0 || almost_full !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got cnt=%0d empty=%b full=%b wa=%0d ra=%0d af=%b",
                      count, empty, full, w_addr, r_addr, almost_full);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 8'h77);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL rstmid_write got=%0d want=1", count); end
  endtask

  task automatic test_random();
    int pw;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pw = ((n / 50) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
           $urandom_range(0, 99) < 10, 8'($urandom));
      total++; if (got_wen !== exp_wen) begin
        bad++; $display("FAIL rnd_wr_en cyc=%0d got=%b want=%b", n, got_wen, exp_wen);
      end
      if (rd_hit) begin
        total++; if (rd_got !== rd_exp) begin
          bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", n, rd_got, rd_exp);
        end
      end
      total++; if (count !== 3'(q.size()) || empty !== (q.size() == 0) ||
                   full !== (q.size() == DEPTH) || almost_full !== (q.size() >= AF)) begin
        bad++; $display("FAIL rnd_level cyc=%0d got cnt=%0d e=%b f=%b af=%b want cnt=%0d",
                        n, count, empty, full, almost_full, q.size());
      end
      total++; if (w_addr !== 2'(mwp) || r_addr !== 2'(mrp)) begin
        bad++; $display("FAIL rnd_addr cyc=%0d got=%0d/%0d want=%0d/%0d", n, w_addr, r_addr, mwp, mrp);
      end
      total++; if (overflow !== mov || underflow !== mun) begin
        bad++; $display("FAIL rnd_err cyc=%0d got=%b%b want=%b%b", n, overflow, underflow, mov, mun);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller for the UART's RX and TX FIFOs. It sits directly upstream of the FIFO register-file storage, supplying its write address, read address and gated write enable, and it reports empty, full, fill level and sticky error flags to the UART core and bus interface. Storage is 2**ADDR_WIDTH entries, with first-word fall-through: the head entry is readable while `empty` is low.

## Interface
- `ADDR_WIDTH`, 2: address width; depth DEPTH = 2**ADDR_WIDTH.
- `AF_LEVEL`, 3: `almost_full` threshold, 1..DEPTH.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr`  in  1  push request; data is presented to storage in the same cycle.
- `rd`  in  1  pop request; consumes the entry at `r_addr`.
- `err_clr`  in  1  clears `overflow` and `underflow`.
- `wr_en`  out  1  storage write enable; equals `wr & ~full` (combinational).
- `w_addr`  out  ADDR_WIDTH  storage write address, equal to the write pointer.
- `r_addr`  out  ADDR_WIDTH  storage read address, equal to the read pointer.
- `empty`  out  1  no valid entries.
- `full`  out  1  DEPTH valid entries.
- `count`  out  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
- `almost_full`  out  1  high when `count >= AF_LEVEL`.
- `overflow`  out  1  sticky; a write was rejected.
- `underflow`  out  1  sticky; a read was rejected.

## Operation
- Registered state:
  - write pointer `wp` and read pointer `rp`, each ADDR_WIDTH bits;
  - `count`, ADDR_WIDTH+1 bits;
  - status flags `empty` and `full`;
  - error flags `overflow` and `underflow`.
- Pointers wrap naturally modulo DEPTH, from DEPTH-1 to 0.
- Accept rules:
  - A write is accepted when `wr & ~full`.
  - A read is accepted when `rd & ~empty`.
- Cases decoded from {accepted wr, accepted rd}:
  - 00: no state change.
  - 10: `wp`+1, `count`+1, `empty`<=0. `full`<=1 if `wp`+1 == `rp`.
  - 01: `rp`+1, `count`-1, `full`<=0. `empty`<=1 if `rp`+1 == `wp`.
  - 11: `wp`+1 and `rp`+1; `count`, `empty` and `full` are unchanged.
- Request `wr & rd` when full: the read is accepted. The write is rejected because `wr_en` is 0 that cycle; the result is case 01 with no overflow.
- Request `wr & rd` when empty: the write is accepted, the read is rejected, and `underflow` sets.
- `overflow` sets on `wr & full & ~rd`.
- `underflow` sets on `rd & empty`.
- Error flags clear on `err_clr`. If a set condition and `err_clr` occur in the same cycle, set wins.
- `count` never exceeds DEPTH and never goes below 0.
- `empty` and `full` are never high together.
- Invariant: `count == (wp - rp) mod DEPTH`, except when full, where it equals DEPTH.

## Timing
- Reset values (asserted asynchronously, independent of `clk`):
  - `wp`=0, `rp`=0, `count`=0;
  - `empty`=1, `full`=0, `almost_full`=0;
  - `overflow`=0, `underflow`=0.
  - `wr_en` follows `wr` while reset is held, because `full`=0.
- Reset mid-operation: all contents are logically discarded, with no handshake or drain.
- Release of reset is synchronous to the system; the first accepted operation is on the first rising edge after deassertion.
- Write latency:
  - `wr_en`, `w_addr` and the data are valid in the same cycle, and storage captures them at that edge.
  - `empty` falls one cycle after an accepted write.
  - The written data is visible on the storage read port in the next cycle.
- Read latency: 0. The data at `r_addr` is valid while `empty`=0, and `rp` advances at the edge on which `rd` is accepted.
- Only `wr_en` has a combinational path from an input.
- `almost_full` is decoded from the registered `count`. All other outputs are registered.

## Test plan
- Reset: assert `reset` with no clock edge -> `empty`=1, `full`=0, `count`=0, `w_addr`=0, `r_addr`=0, both errors 0.
- Fill (DEPTH=4): 4 consecutive `wr` cycles -> `count` steps 1,2,3,4; `almost_full`=1 at count 3; `full`=1 after the 4th write; `w_addr` wraps to 0.
- Overflow: at full, one `wr` without `rd` -> `wr_en`=0, no state change, `overflow`=1. Then pulse `err_clr` -> `overflow`=0.
- Drain and wrap: write A,B,C, read 2, write D,E,F -> `w_addr` wraps; reads return C,D,E,F in order; `empty`=1 after the last read. Then one `rd` -> `underflow`=1, `r_addr` unchanged.
- Simultaneous `wr & rd`:
  - at count 2 -> `count` stays 2 and both addresses advance;
  - at empty -> `count`=1 and `underflow`=1;
  - at full -> `count`=3 with no overflow.
- Reset mid-stream: assert `reset` at count 3, between clock edges -> all outputs return to reset values immediately; after release, a single write produces `count`=1.
